// File: rtl/parity_pkg.sv
// Shared encodings and lane-selection helper for the parity framed serial transmitter.
package parity_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  localparam logic MODE_8 = 1'b0;
  localparam logic MODE_4 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_START  = S_START,
    ST_DATA   = S_DATA,
    ST_PARITY = S_PARITY,
    ST_STOP   = S_STOP
  } state_e;

  // 4-bit frames carry the even lanes, packed low with d0 first on the line.
  function automatic logic [7:0] select_lanes(input logic [7:0] d, input logic mode);
    if (mode == MODE_4) return {4'b0000, d[6], d[4], d[2], d[0]};
    return d;
  endfunction

endpackage

// File: rtl/parity_frame_tx_if.sv
// Producer-side handshake plus serial/status outputs of the framed transmitter.
interface parity_frame_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_mode;
  logic       tx;
  logic       busy;
  logic       done;
  logic       par_bit;

  modport master (
    output in_valid, in_data, in_mode,
    input  in_ready, tx, busy, done, par_bit
  );

  modport slave (
    input  in_valid, in_data, in_mode,
    output in_ready, tx, busy, done, par_bit
  );
endinterface

// File: rtl/parity_calc.sv
// Combinational XOR reduction producing an even or odd parity bit.
module parity_calc #(
  parameter int N   = 8,
  parameter int ODD = 0
) (
  input  logic [N-1:0] d,
  output logic         p
);
  assign p = (^d) ^ (ODD != 0);
endmodule

// File: rtl/parity_frame_tx.sv
// Framed serial transmitter: start, LSB-first data, parity, stop, each CLKS_PER_BIT cycles.
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = 0
) (
  input  logic               clk,
  input  logic               rst,
  parity_frame_tx_if.slave   bus
);

  localparam int BW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [2:0]      last_q, last_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            par_q, par_d;
  logic [7:0]      sel;
  logic            par_new;
  logic            boundary;
  logic            accept;

  assign sel      = select_lanes(bus.in_data, bus.in_mode);
  assign accept   = bus.in_valid && (state_q == ST_IDLE);
  assign boundary = (baud_q == BAUD_LAST);

  // Zero padding of the 4-bit lanes leaves the reduction unchanged.
  parity_calc #(.N(8), .ODD(ODD_PARITY)) u_parity_calc (
    .d(sel),
    .p(par_new)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    last_d  = last_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    if (state_q != ST_IDLE) baud_d = boundary ? '0 : baud_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          shift_d = sel;
          last_d  = (bus.in_mode == MODE_4) ? 3'd3 : 3'd7;
          par_d   = par_new;
        end
      end
      ST_START: begin
        if (boundary) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (boundary) begin
          shift_d = shift_q >> 1;
          if (bit_q == last_q) state_d = ST_PARITY;
          else                 bit_d   = bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (boundary) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (boundary) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the state being entered, so tx only moves on bit boundaries.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    last_q  <= last_d;
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      par_q   <= par_d;
    end
  end

  assign bus.in_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.tx       = tx_q;
  assign bus.done     = done_q;
  assign bus.par_bit  = par_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Scoreboard bench: instance 0 is 4 clocks/bit even parity, instance 1 is 1 clock/bit odd parity.
module tb_parity_frame_tx;
  import parity_pkg::*;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v   = '1;
  logic [NI-1:0] valid_v = '0;
  logic [NI-1:0] mode_v  = '0;
  logic [NI-1:0] rdy_v;
  logic [7:0]    data_v [NI];

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic tx;
    logic busy;
    logic done;
    logic par;
  } exp_t;

  function automatic void chk(string nm, int inst, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d @%0t: got %b expected %b", nm, inst, $time, act, exp);
    end
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g
    localparam int CPB = (gi == 0) ? 4 : 1;
    localparam int ODD = (gi == 0) ? 0 : 1;

    parity_frame_tx_if vif();
    assign vif.in_valid = valid_v[gi];
    assign vif.in_data  = data_v[gi];
    assign vif.in_mode  = mode_v[gi];
    assign rdy_v[gi]    = vif.in_ready;

    parity_frame_tx #(.CLKS_PER_BIT(CPB), .ODD_PARITY(ODD)) dut (
      .clk(clk),
      .rst(rst_v[gi]),
      .bus(vif)
    );

    exp_t q[$];
    bit   started = 1'b0;
    bit   acc_pend, rst_pend;
    logic cur_par;

    // Reference frame: line bits listed from the protocol, each held CPB cycles, then one done cycle.
    function automatic void push_frame(input logic [7:0] d, input logic m);
      logic bits[$];
      logic p;
      exp_t e;
      p = (ODD != 0);
      bits.push_back(1'b0);
      for (int k = 0; k < ((m == MODE_4) ? 4 : 8); k++) begin
        logic b;
        b = (m == MODE_4) ? d[2*k] : d[k];
        bits.push_back(b);
        p = p ^ b;
      end
      bits.push_back(p);
      bits.push_back(1'b1);
      foreach (bits[k]) begin
        for (int c = 0; c < CPB; c++) begin
          e.tx = bits[k]; e.busy = 1'b1; e.done = 1'b0; e.par = p;
          q.push_back(e);
        end
      end
      e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b1; e.par = p;
      q.push_back(e);
    endfunction

    always @(negedge clk) begin
      acc_pend = valid_v[gi] && rdy_v[gi];
      rst_pend = rst_v[gi];
    end

    always @(posedge clk) begin
      if (rst_pend) begin
        exp_t e;
        q.delete();
        e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.par = 1'b0;
        q.push_back(e);
        started = 1'b1;
      end else if (acc_pend) begin
        push_frame(data_v[gi], mode_v[gi]);
      end
    end

    always @(negedge clk) begin
      if (started) begin
        exp_t e;
        if (q.size() > 0) e = q.pop_front();
        else begin
          e.tx = 1'b1; e.busy = 1'b0; e.done = 1'b0; e.par = cur_par;
        end
        cur_par = e.par;
        chk("tx",       gi, vif.tx,       e.tx);
        chk("busy",     gi, vif.busy,     e.busy);
        chk("done",     gi, vif.done,     e.done);
        chk("in_ready", gi, vif.in_ready, !e.busy);
        chk("par_bit",  gi, vif.par_bit,  e.par);
      end
    end
  end

  task automatic send(input int i, input logic [7:0] d, input logic m);
    bit ok;
    valid_v[i] = 1'b1;
    data_v[i]  = d;
    mode_v[i]  = m;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      ok = rdy_v[i] && !rst_v[i];
      @(posedge clk);
      #1;
      if (ok) begin
        valid_v[i] = 1'b0;
        return;
      end
    end
    vectors++;
    miscompares++;
    $display("FAIL accept_timeout inst%0d: got no accept expected accept within 400 cycles", i);
    valid_v[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    data_v[0] = 8'h00;
    data_v[1] = 8'h00;
    idle(2);
    rst_v = '0;
    idle(20);

    send(0, 8'hA5, 1'b0);
    idle(50);
    send(0, 8'h01, 1'b1);
    idle(35);

    send(0, 8'h55, 1'b1);
    send(0, 8'hFF, 1'b0);
    idle(50);

    // Reset lands inside the fourth data bit slot of the frame.
    send(0, 8'hA5, 1'b0);
    idle(17);
    rst_v[0] = 1'b1;
    idle(1);
    rst_v[0] = 1'b0;
    idle(3);
    send(0, 8'h80, 1'b0);
    idle(50);

    send(1, 8'h00, 1'b0);
    idle(15);
    send(1, 8'hFF, 1'b1);
    send(1, 8'h3C, 1'b0);
    idle(15);

    for (int n = 0; n < 24; n++) begin
      int inst;
      inst = n % 2;
      send(inst, 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 50));
    end
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
Name: parity_frame_tx

Overview:
- Controller that sequences the parity datapath into a framed serial link.
- Accepts one byte per valid/ready handshake and selects either full 8-bit framing or 4-bit framing; 4-bit framing uses lane bits {d[6],d[4],d[2],d[0]}.
- Computes the parity bit, then shifts out start, data (LSB first), parity and stop bits at a programmable bit rate.
- Sits between the byte producer and the serial line driver.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 1..65535.
- ODD_PARITY, 0, 0 selects even parity (parity bit = XOR of data bits); 1 selects odd parity (the inverted XOR).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents in_data/in_mode.
- in_ready  output  1  block can accept a frame request.
- in_data  input  8  payload byte.
- in_mode  input  1  0 = 8-bit frame; 1 = 4-bit frame from bits {6,4,2,0}.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.
- par_bit  output  1  parity bit of the last accepted frame; holds until the next accept.

Behaviour:
- Reset values (from the cycle after rst is sampled high):
  - state IDLE, tx=1, busy=0, done=0, par_bit=0, in_ready=1.
  - Any handshake in a cycle where rst=1 is ignored.
- Reset mid-frame aborts immediately: tx returns to 1 on the next cycle, and no done pulse is produced.
- in_ready = (state==IDLE).
- Accept: in_valid && in_ready at a rising edge. On accept the block registers:
  - the shift register: in_data in 8-bit mode; {4'b0, d6,d4,d2,d0} in 4-bit mode, with d0 in bit 0;
  - nbits: 8 or 4;
  - par_bit: XOR of the selected data bits, inverted if ODD_PARITY=1.
- in_data/in_mode are don't-care outside the accept cycle.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
- Every non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a baud counter that counts 0..CLKS_PER_BIT-1 and then wraps.
- START: tx=0.
- DATA:
  - tx = shift[0]; the register shifts right at each bit boundary.
  - A bit counter runs 0..nbits-1; on the last bit boundary the FSM moves to PARITY.
- PARITY: tx=par_bit.
- STOP: tx=1.
- tx is registered and changes only on bit boundaries.
- Latency: the first START cycle on tx is the cycle after accept.
- Frame length: 11*CLKS_PER_BIT cycles in 8-bit mode, 7*CLKS_PER_BIT in 4-bit mode.
- done:
  - Asserted for one cycle in the first IDLE cycle after STOP completes.
  - in_ready is also 1 in that cycle, so a back-to-back accept is legal.
  - A frame accepted in that cycle starts START on the next cycle, giving no gap in the line.
- busy = (state != IDLE).
- in_valid held high while busy causes no action and no loss: the request is accepted when in_ready returns.
- CLKS_PER_BIT=1: one cycle per bit; the counter is always 0 and every cycle is a boundary.
- Counter widths: $clog2(CLKS_PER_BIT)+1 bits for the baud counter, 3 bits for the bit counter; no overflow is permitted.

Decomposition:
- Shared package parity_pkg:
  - state encoding localparams S_IDLE=0, S_START=1, S_DATA=2, S_PARITY=3, S_STOP=4 (3 bits);
  - MODE_8=1'b0, MODE_4=1'b1.
- One sub-module, parity_calc: a combinational N-bit XOR reduction with an odd/even parameter.
  - It is instantiated once on the selected, zero-padded 8-bit vector; the zero padding does not change the XOR result.
- The FSM, baud counter and shift register stay in parity_frame_tx.

Test Plan:
- Reset then idle: rst high 2 cycles, then release -> tx=1, in_ready=1, busy=0, done=0 held for 20 cycles.
- 8-bit even, CLKS_PER_BIT=4, in_data=0xA5, in_mode=0 -> par_bit=0; tx sequence per 4-cycle slot 0,1,0,1,0,0,1,0,1,0,1; done pulses exactly 44 cycles after accept.
- 4-bit mode, in_data=0x01, in_mode=1 -> nibble 0001, par_bit=1; tx slots 0,1,0,0,0,1,1; frame is 28 cycles.
- Back-to-back: in_valid held high with 0x55 (mode 1) then 0xFF (mode 0) -> second accept happens in the done cycle; no idle-high gap between the first STOP and the second START; par_bit=0 for both frames.
- Reset mid-frame: assert rst during the DATA bit 3 slot of 0xA5 -> next cycle tx=1, busy=0, no done pulse; the next frame 0x80 (mode 0) transmits correctly with par_bit=1.
- ODD_PARITY=1, CLKS_PER_BIT=1, in_data=0x00, in_mode=0 -> par_bit=1; tx = 0,0,0,0,0,0,0,0,0,1,1 on consecutive cycles.
